// File: rtl/note_game_pkg.sv
// Shared definitions for the note-game lane interface: lane codes used by the
// judge and display blocks, the encoder state type and small encoding helpers.
package note_game_pkg;

  localparam logic [2:0] LANE_NONE = 3'd0;
  localparam logic [2:0] LANE_1    = 3'd1;
  localparam logic [2:0] LANE_2    = 3'd2;
  localparam logic [2:0] LANE_3    = 3'd3;
  localparam logic [2:0] LANE_4    = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    CHORD = 2'd2
  } lane_state_e;

  // Number of buttons currently down in a debounced vector.
  function automatic logic [2:0] popcount4(input logic [3:0] d);
    return 3'(d[0]) + 3'(d[1]) + 3'(d[2]) + 3'(d[3]);
  endfunction

  // Lane code for a one-hot debounced vector; LANE_NONE for anything else.
  function automatic logic [2:0] lane_of(input logic [3:0] d);
    logic [2:0] code;
    case (d)
      4'b0001: code = LANE_1;
      4'b0010: code = LANE_2;
      4'b0100: code = LANE_3;
      4'b1000: code = LANE_4;
      default: code = LANE_NONE;
    endcase
    return code;
  endfunction

  // One-hot button pattern that corresponds to a lane code.
  function automatic logic [3:0] onehot_of(input logic [2:0] lane);
    logic [3:0] oh;
    case (lane)
      LANE_1:  oh = 4'b0001;
      LANE_2:  oh = 4'b0010;
      LANE_3:  oh = 4'b0100;
      LANE_4:  oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: two-flop synchroniser followed by a
// stability counter. The debounced level only follows the synchronised input
// after it has differed from it for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has persisted for the full window;
  // any agreement with the current level restarts the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_p1 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_p1;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_lane_encoder.sv
// Lane encoder for the note game: debounces the four player buttons and turns
// clean single-button presses into press/release events with a held lane code.
// Any multi-button combination is rejected as a chord until all are released.
module button_lane_encoder
  import note_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       b4,
  output logic [2:0] lane,
  output logic       press_evt,
  output logic       rel_evt,
  output logic       chord,
  output logic       l1,
  output logic       l2,
  output logic       l3,
  output logic       l4
);

  logic [3:0]  btn_raw;
  logic [3:0]  d;
  logic [2:0]  n;
  logic [3:0]  leds;
  lane_state_e state;

  assign btn_raw = {b4, b3, b2, b1};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[i]),
      .stable(d[i])
    );
  end

  assign n = popcount4(d);

  // Encoder FSM with registered events, lane code, chord flag and LEDs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lane      <= LANE_NONE;
      press_evt <= 1'b0;
      rel_evt   <= 1'b0;
      chord     <= 1'b0;
      leds      <= 4'b0000;
    end else begin
      press_evt <= 1'b0;
      rel_evt   <= 1'b0;
      case (state)
        IDLE: begin
          if (n == 3'd1) begin
            state     <= HELD;
            press_evt <= 1'b1;
            lane      <= lane_of(d);
            leds      <= d;
          end else if (n >= 3'd2) begin
            state <= CHORD;
            chord <= 1'b1;
          end
        end
        HELD: begin
          if (d != onehot_of(lane)) begin
            rel_evt <= 1'b1;
            lane    <= LANE_NONE;
            leds    <= 4'b0000;
            if (d == 4'b0000) begin
              state <= IDLE;
            end else begin
              state <= CHORD;
              chord <= 1'b1;
            end
          end
        end
        CHORD: begin
          if (d == 4'b0000) begin
            state <= IDLE;
            chord <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          lane  <= LANE_NONE;
          chord <= 1'b0;
          leds  <= 4'b0000;
        end
      endcase
    end
  end

  assign l1 = leds[0];
  assign l2 = leds[1];
  assign l3 = leds[2];
  assign l4 = leds[3];

endmodule
